register_bank_rf: RTL
=====================

// Module: register_bank_rf
// PURPOSE
//  Parametrised register file for the 32-bit processor datapath: NUM_REGS x DATA_W storage,
//  one write port with one-hot write decode, two registered read ports.
//  Adds a per-register busy scoreboard (reserve at issue, clear at writeback) for hazard stalls.
//  Sits between decode (read/reserve) and writeback (write).
// PARAMETERS
//  NUM_REGS  16  number of architectural registers (2..64)
//  DATA_W    32  register width in bits
//  ADDR_W    $clog2(NUM_REGS)  address width (derived, not overridden)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never becomes busy
// PORTS
//  clk              in   1         rising-edge clock
//  resetN           in   1         asynchronous active-low reset
//  writeEnable      in   1         write writeData into destination this edge
//  destination      in   ADDR_W    write address
//  writeData        in   DATA_W    write data
//  registerAddress  out  NUM_REGS  one-hot decode of destination, all-zero when !writeEnable
//  readAddrA/B      in   ADDR_W    read addresses, sampled at clk edge
//  readDataA/B      out  DATA_W    registered read data
//  reserveEnable    in   1         mark reserveAddr busy this edge
//  reserveAddr      in   ADDR_W    register to reserve
//  busyA/busyB      out  1         combinational busy[readAddrA]/busy[readAddrB]
//  busyMask         out  NUM_REGS  current scoreboard
// BEHAVIOUR
//  - Reset (resetN=0, async): all registers, readDataA/B, busyMask = 0; holds while low.
//  - Write: at posedge with writeEnable, reg[destination] <= writeData; busy[destination] <= 0.
//  - registerAddress: combinational, bit destination set iff writeEnable and address valid.
//  - Read: readDataX <= reg[readAddrX] at posedge; 1-cycle latency; ports independent.
//  - Reads of address 0 with ZERO_REG=1 return 0; writes/reserves to reg 0 are no-ops.
//  - Addresses >= NUM_REGS (non-power-of-2 depth): writes/reserves ignored, reads return 0,
//    registerAddress all-zero, busy reads 0.
//  - Reserve: at posedge with reserveEnable, busy[reserveAddr] <= 1.
//  - Simultaneous reserve and write to same address: reserve wins (busy ends 1, data written).
//  - Read-during-write same address same edge: see CONFIGURATION.
//  - busyA/B reflect the scoreboard before the current edge (no bypass of reserve/clear).
//  - Reset asserted mid-operation: pending write/reserve discarded; state as at reset.
// CONFIGURATION
//  RF_BYPASS_EN defined: read of address being written this edge returns writeData next cycle
//   (write-to-read forwarding; not applied to reg 0 when ZERO_REG=1).
//  RF_BYPASS_EN undefined: such a read returns the pre-write value; new value visible one
//   cycle later.
// STRUCTURE
//  register_bank_pkg: default NUM_REGS/DATA_W constants, reg_addr_t/reg_data_t typedefs.
//  Sub-module one_hot_decoder (N outputs, enable input) generates registerAddress and the
//   internal write/reserve/clear strobes; instantiated for write and reserve decode.
// TESTING
//  1 Reset: resetN=0 mid-traffic -> readDataA/B=0, busyMask=0 immediately, reg reads 0 after.
//  2 Write 0xDEADBEEF to r5, next cycle readAddrA=5 -> readDataA=0xDEADBEEF one cycle later;
//    registerAddress=0x0020 during write cycle.
//  3 Same-edge write r7=0x12345678 and readAddrB=7 (r7 was 0) -> readDataB=0x12345678 with
//    RF_BYPASS_EN, 0x00000000 without; 0x12345678 on following read either way.
//  4 ZERO_REG=1: write r0=0xFFFFFFFF, reserve r0 -> readDataA=0, busyMask=0, registerAddress=0.
//  5 Reserve r3 -> busyA=1 with readAddrA=3 next cycle; write r3 -> busy clears after edge;
//    reserve+write r3 same edge -> busyMask[3]=1.
//  6 NUM_REGS=12: write addr 13 ignored, read addr 13 -> 0; sweep all valid addresses
//    write i*0x11111111 then read back on both ports -> values match.

Source files
------------

// File: rtl/register_bank_pkg.sv
// ============================================================================
// Module      : register_bank_pkg
// Description : Shared defaults and typedefs for the register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_bank_pkg;

  // Default geometry of the architectural register file
  localparam int C_NUM_REGS_DEF = 16;
  localparam int C_DATA_W_DEF   = 32;
  localparam int C_ADDR_W_DEF   = $clog2(C_NUM_REGS_DEF);

  typedef logic [C_ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [C_DATA_W_DEF-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/one_hot_decoder.sv
// ============================================================================
// Module      : one_hot_decoder
// Description : Enabled binary-to-one-hot decoder. Addresses >= N decode to
//               all-zero; bit 0 can be suppressed for a hard-wired zero reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_hot_decoder
  import register_bank_pkg::*;
#(
  parameter int N         = C_NUM_REGS_DEF,
  parameter int AW        = C_ADDR_W_DEF,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  onehot
);

  // One comparator per output; unreachable addresses simply match nothing
  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (SKIP_ZERO && (i == 0)) begin : g_zero
        assign onehot[i] = 1'b0;
      end else begin : g_dec
        assign onehot[i] = en && (addr == AW'(i));
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/register_bank_rf.sv
// ============================================================================
// Module      : register_bank_rf
// Description : NUM_REGS x DATA_W register file, one write port, two
//               registered read ports, per-register busy scoreboard.
//               Optional macro RF_BYPASS_EN enables write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_bank_rf
  import register_bank_pkg::*;
#(
  parameter int NUM_REGS = C_NUM_REGS_DEF,
  parameter int DATA_W   = C_DATA_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        writeEnable,
  input  logic [$clog2(NUM_REGS)-1:0] destination,
  input  logic [DATA_W-1:0]           writeData,
  output logic [NUM_REGS-1:0]         registerAddress,
  input  logic [$clog2(NUM_REGS)-1:0] readAddrA,
  input  logic [$clog2(NUM_REGS)-1:0] readAddrB,
  output logic [DATA_W-1:0]           readDataA,
  output logic [DATA_W-1:0]           readDataB,
  input  logic                        reserveEnable,
  input  logic [$clog2(NUM_REGS)-1:0] reserveAddr,
  output logic                        busyA,
  output logic                        busyB,
  output logic [NUM_REGS-1:0]         busyMask
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [DATA_W-1:0]   r_rd_a;
  logic [DATA_W-1:0]   r_rd_b;
  logic [NUM_REGS-1:0] w_wr_hot;
  logic [NUM_REGS-1:0] w_rsv_hot;
  logic [NUM_REGS-1:0] w_fwd;
  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;
  logic                w_busy_a;
  logic                w_busy_b;

  // Write strobes; register 0 never decodes when it is hard-wired to zero
  one_hot_decoder #(
    .N         (NUM_REGS),
    .AW        (ADDR_W),
    .SKIP_ZERO (ZERO_REG != 0)
  ) u_wr_dec (
    .en     (writeEnable),
    .addr   (destination),
    .onehot (w_wr_hot)
  );

  // Reserve strobes share the same validity rules as writes
  one_hot_decoder #(
    .N         (NUM_REGS),
    .AW        (ADDR_W),
    .SKIP_ZERO (ZERO_REG != 0)
  ) u_rsv_dec (
    .en     (reserveEnable),
    .addr   (reserveAddr),
    .onehot (w_rsv_hot)
  );

`ifdef RF_BYPASS_EN
  // A read of the register being written this edge sees the new data
  assign w_fwd = w_wr_hot;
`else
  // Reads always see the stored (pre-write) value
  assign w_fwd = '0;
`endif

  // Read-address muxes; out-of-range addresses fall through to zero
  always_comb begin
    w_rd_a   = '0;
    w_rd_b   = '0;
    w_busy_a = 1'b0;
    w_busy_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (readAddrA == ADDR_W'(i)) begin
        w_rd_a   = w_fwd[i] ? writeData : r_regs[i];
        w_busy_a = r_busy[i];
      end
      if (readAddrB == ADDR_W'(i)) begin
        w_rd_b   = w_fwd[i] ? writeData : r_regs[i];
        w_busy_b = r_busy[i];
      end
    end
  end

  // Register storage; an unwritten zero register stays at its reset value
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hot[i]) begin
          r_regs[i] <= writeData;
        end
      end
    end
  end

  // Scoreboard: writeback clears, issue sets; set applied last so it wins
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wr_hot) | w_rsv_hot;
    end
  end

  // Registered read ports, one cycle latency
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rd_a <= '0;
      r_rd_b <= '0;
    end else begin
      r_rd_a <= w_rd_a;
      r_rd_b <= w_rd_b;
    end
  end

  assign registerAddress = w_wr_hot;
  assign readDataA       = r_rd_a;
  assign readDataB       = r_rd_b;
  assign busyA           = w_busy_a;
  assign busyB           = w_busy_b;
  assign busyMask        = r_busy;

endmodule

`default_nettype wire
